uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and parameter defaults.
package uart_arb_pkg;

  localparam int NUM_REQ_DEFAULT       = 4;
  localparam int STALL_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FETCH      = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first active request at or above ptr, wrapping.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_req
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Wrapped index kept one bit wider so ptr + offset never overflows before the wrap.
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding one UART transmitter, one byte at a time.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEFAULT,
  parameter int STALL_TIMEOUT = STALL_TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_enable_o,
  input  logic                 tx_busy_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 abort_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               last_q, last_d;
  logic               tx_en_q, tx_en_d;
  logic               abort_q, abort_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic               any_req;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic               handshake;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid_i),
    .ptr     (rr_ptr_q),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  // Mux the owner's byte and recover its index; grant_q is one-hot or zero.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_data  = sel_data | req_data_i[8*k +: 8];
        sel_last  = sel_last | req_last_i[k];
        grant_idx = PTR_W'(k);
      end
    end
  end

  assign next_ptr  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
  assign handshake = (state_q == ST_FETCH) && |(req_valid_i & grant_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    stall_d   = stall_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    tx_en_d   = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = arb_grant;
          stall_d = '0;
          state_d = ST_FETCH;
        end
      end
      // A byte arriving in the final stall cycle takes priority over the abort.
      ST_FETCH: begin
        if (handshake) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          tx_en_d   = 1'b1;
          state_d   = ST_WAIT_START;
        end else if (stall_q == STALL_LAST) begin
          abort_d  = 1'b1;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      ST_WAIT_START: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          if (last_q) begin
            grant_d  = '0;
            rr_ptr_d = next_ptr;
            state_d  = ST_IDLE;
          end else begin
            stall_d = '0;
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      stall_q   <= '0;
      tx_data_q <= 8'h00;
      last_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      stall_q   <= stall_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
      tx_en_q   <= tx_en_d;
      abort_q   <= abort_d;
    end
  end

  assign req_ready_o = (state_q == ST_FETCH) ? grant_q : '0;
  assign tx_data_o   = tx_data_q;
  assign tx_enable_o = tx_en_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign abort_o     = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, UART busy model and byte scoreboard.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 1024;

  typedef struct { logic [7:0] data; logic last; } src_byte_t;
  typedef struct { logic [7:0] data; logic [NREQ-1:0] grant; } exp_t;
  typedef struct { int src; logic [7:0] b0; logic [7:0] b1; logic [NREQ-1:0] exp_grant; } vec_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [8*NREQ-1:0] req_data_i = '0;
  logic [NREQ-1:0]   req_last_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic [7:0]        tx_data_o;
  logic              tx_enable_o;
  logic              tx_busy_i = 1'b0;
  logic [NREQ-1:0]   grant_o;
  logic              busy_o;
  logic              abort_o;

  int total = 0;
  int bad = 0;
  int abort_count = 0;
  int enable_count = 0;
  int exp_pushed = 0;
  int busy_cnt = 0;

  src_byte_t src_q[NREQ][$];
  exp_t      exp_q[$];
  vec_t      vec[4];

  uart_tx_arbiter #(
    .NUM_REQ       (NREQ),
    .STALL_TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_enable_o (tx_enable_o),
    .tx_busy_i   (tx_busy_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .abort_o     (abort_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // exp_grant of zero marks a byte that must never reach the transmitter.
  task automatic applyStimulus(input int src, input logic [7:0] data, input logic last,
                               input logic [NREQ-1:0] exp_grant);
    src_byte_t b;
    exp_t      e;
    b.data = data;
    b.last = last;
    src_q[src].push_back(b);
    if (exp_grant != '0) begin
      e.data  = data;
      e.grant = exp_grant;
      exp_q.push_back(e);
      exp_pushed++;
    end
  endtask

  function automatic bit srcEmpty();
    for (int k = 0; k < NREQ; k++) begin
      if (src_q[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic waitIdle(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      done = (busy_o == 1'b0) && (exp_q.size() == 0) && srcEmpty();
    end
    checkOutput({name, "_idle_reached"}, 32'(done), 32'd1);
  endtask

  task automatic waitEnable(input string name, output int cycles);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 4000) begin
      @(negedge clk);
      n++;
      seen = tx_enable_o;
    end
    cycles = n;
    checkOutput({name, "_enable_seen"}, 32'(seen), 32'd1);
  endtask

  // Requester queues and UART busy model: sample at negedge, update just after posedge.
  initial begin
    logic [NREQ-1:0] hs;
    logic            en_seen;
    forever begin
      @(negedge clk);
      hs      = req_valid_i & req_ready_o;
      en_seen = tx_enable_o;
      @(posedge clk);
      #1;
      if (en_seen) busy_cnt = 3;
      else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      tx_busy_i = (busy_cnt != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          req_valid_i[k]        = 1'b1;
          req_data_i[8*k +: 8] = src_q[k][0].data;
          req_last_i[k]         = src_q[k][0].last;
        end else begin
          req_valid_i[k]        = 1'b0;
          req_data_i[8*k +: 8] = 8'h00;
          req_last_i[k]         = 1'b0;
        end
      end
    end
  end

  // Scoreboard side: every transmitter start must match the next expected byte and owner.
  initial begin
    logic prev_en;
    exp_t e;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (abort_o) abort_count++;
        if (tx_enable_o) begin
          enable_count++;
          checkOutput("enable_one_cycle", 32'(prev_en), 32'd0);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_byte actual=%02h required=none", tx_data_o);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_data", 32'(tx_data_o), 32'(e.data));
            checkOutput("sb_grant", 32'(grant_o), 32'(e.grant));
          end
        end
        prev_en = tx_enable_o;
      end else begin
        prev_en = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    int fetch_cycles;
    int aborts0;
    int n;
    bit seen;

    vec[0] = '{src: 0, b0: 8'h55, b1: 8'hA3, exp_grant: 4'b0001};
    vec[1] = '{src: 2, b0: 8'h3C, b1: 8'hC3, exp_grant: 4'b0100};
    vec[2] = '{src: 1, b0: 8'h00, b1: 8'hFF, exp_grant: 4'b0010};
    vec[3] = '{src: 3, b0: 8'h81, b1: 8'h7E, exp_grant: 4'b1000};

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 32'(grant_o), 32'd0);
    checkOutput("rst_enable", 32'(tx_enable_o), 32'd0);
    checkOutput("rst_data", 32'(tx_data_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_abort", 32'(abort_o), 32'd0);
    checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] two-byte packets from single requesters");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vec[i].src, vec[i].b0, 1'b0, vec[i].exp_grant);
      applyStimulus(vec[i].src, vec[i].b1, 1'b1, vec[i].exp_grant);
      waitIdle($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_grant_clear", i), 32'(grant_o), 32'd0);
      checkOutput($sformatf("vec%0d_ready_clear", i), 32'(req_ready_o), 32'd0);
    end

    $display("[TB] fairness with all requesters busy");
    for (int r = 0; r < 2; r++) begin
      applyStimulus(0, 8'hA0 + 8'(r), 1'b1, 4'b0001);
      applyStimulus(1, 8'hB0 + 8'(r), 1'b1, 4'b0010);
      applyStimulus(2, 8'hC0 + 8'(r), 1'b1, 4'b0100);
      applyStimulus(3, 8'hD0 + 8'(r), 1'b1, 4'b1000);
    end
    waitIdle("fair");

    $display("[TB] contention between req1 and req2");
    applyStimulus(1, 8'h10, 1'b0, 4'b0010);
    applyStimulus(1, 8'h11, 1'b0, 4'b0010);
    applyStimulus(1, 8'h12, 1'b1, 4'b0010);
    applyStimulus(2, 8'h20, 1'b0, 4'b0100);
    applyStimulus(2, 8'h21, 1'b1, 4'b0100);
    waitIdle("contend");

    $display("[TB] pointer advance and start latency");
    applyStimulus(0, 8'h55, 1'b0, 4'b0001);
    applyStimulus(0, 8'hA3, 1'b1, 4'b0001);
    waitEnable("latency", cyc);
    checkOutput("latency_cycles", 32'(cyc), 32'd3);
    waitIdle("single");
    applyStimulus(1, 8'h02, 1'b1, 4'b0010);
    applyStimulus(0, 8'h01, 1'b1, 4'b0001);
    waitIdle("ptr_after_req0");

    $display("[TB] stall timeout");
    aborts0 = abort_count;
    applyStimulus(3, 8'h11, 1'b0, 4'b1000);
    applyStimulus(0, 8'h77, 1'b1, 4'b0001);
    waitEnable("stall_first", cyc);
    fetch_cycles = 0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (abort_o) seen = 1'b1;
      else if (req_ready_o[3]) fetch_cycles++;
    end
    checkOutput("stall_abort_seen", 32'(seen), 32'd1);
    checkOutput("stall_fetch_cycles", 32'(fetch_cycles), 32'(TIMEOUT));
    checkOutput("stall_grant_clear", 32'(grant_o), 32'd0);
    checkOutput("stall_busy_clear", 32'(busy_o), 32'd0);
    waitIdle("stall");
    checkOutput("stall_abort_count", 32'(abort_count - aborts0), 32'd1);

    $display("[TB] byte arrives in last stall cycle");
    aborts0 = abort_count;
    applyStimulus(2, 8'h42, 1'b0, 4'b0100);
    waitEnable("race_first", cyc);
    fetch_cycles = 0;
    n = 0;
    while (fetch_cycles < TIMEOUT - 1 && n < 3000) begin
      @(negedge clk);
      n++;
      if (req_ready_o[2]) fetch_cycles++;
    end
    checkOutput("race_reach", 32'(fetch_cycles), 32'(TIMEOUT - 1));
    applyStimulus(2, 8'h43, 1'b1, 4'b0100);
    waitIdle("race");
    checkOutput("race_no_abort", 32'(abort_count - aborts0), 32'd0);

    $display("[TB] reset during WAIT_DONE");
    aborts0 = abort_count;
    applyStimulus(1, 8'h5A, 1'b0, 4'b0010);
    applyStimulus(1, 8'h5B, 1'b1, 4'b0000);
    waitEnable("rst_first", cyc);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mid_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0;
    src_q[1].delete();
    @(negedge clk);
    checkOutput("rst_mid_grant", 32'(grant_o), 32'd0);
    checkOutput("rst_mid_enable", 32'(tx_enable_o), 32'd0);
    checkOutput("rst_mid_data", 32'(tx_data_o), 32'd0);
    checkOutput("rst_mid_busyo", 32'(busy_o), 32'd0);
    checkOutput("rst_mid_abort", 32'(abort_o), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("rst_mid_no_abort", 32'(abort_count - aborts0), 32'd0);
    checkOutput("rst_mid_idle", 32'(busy_o), 32'd0);

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("enable_total", 32'(enable_count), 32'(exp_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
